// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per clock; MTHI/MTLO write HI/LO directly.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            alu_operation_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MTHI  = 4'b1100;
  localparam logic [3:0] OP_MTLO  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
  logic [W-1:0]     hi_q, lo_q;

  logic             is_div_q;
  logic [W-1:0]     opnd_q;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W:0]       trial;
  logic [W:0]       mul_sum;
  logic             last_iter;
  logic             load_md;

  assign last_iter = (cnt_q == CNT_W'(W - 1));
  assign load_md   = (state_q == S_IDLE) && start_i &&
                     ((alu_operation_i == OP_MULTU) ||
                      ((alu_operation_i == OP_DIVU) && (rt_data_i != '0)));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc[W-1:0] shifts dividend bits out of the top and quotient bits in at the bottom.
  always_comb begin
    acc_d   = acc_q;
    rem_d   = rem_q;
    trial   = '0;
    mul_sum = '0;
    if (is_div_q) begin
      trial = {rem_q, acc_q[W-1]} - {1'b0, opnd_q};
      if (!trial[W]) begin
        rem_d = trial[W-1:0];
        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[W-2:0], acc_q[W-1]};
        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
      end
    end else begin
      mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      acc_d   = {mul_sum, acc_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            case (alu_operation_i)
              OP_MULTU: begin
                state_q <= S_RUN;
                cnt_q   <= '0;
                dbz_q   <= 1'b0;
              end
              OP_DIVU: begin
                if (rt_data_i == '0) begin
                  state_q <= S_DONE;
                  hi_q    <= rs_data_i;
                  lo_q    <= '1;
                  dbz_q   <= 1'b1;
                end else begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  dbz_q   <= 1'b0;
                end
              end
              OP_MTHI: hi_q <= rs_data_i;
              OP_MTLO: lo_q <= rs_data_i;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= S_DONE;
            hi_q    <= is_div_q ? rem_d : acc_d[2*W-1:W];
            lo_q    <= acc_d[W-1:0];
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Working registers carry no architectural state, so they need no reset.
  always_ff @(posedge clk) begin
    if (load_md) begin
      is_div_q <= (alu_operation_i == OP_DIVU);
      opnd_q   <= (alu_operation_i == OP_DIVU) ? rt_data_i : rs_data_i;
      acc_q    <= {{W{1'b0}}, ((alu_operation_i == OP_DIVU) ? rs_data_i : rt_data_i)};
      rem_q    <= '0;
    end else if (state_q == S_RUN) begin
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a timeline-level arithmetic model.
module tb_mult_div_unit;
  localparam logic [3:0] MULTU = 4'b1010;
  localparam logic [3:0] DIVU  = 4'b1011;
  localparam logic [3:0] MTHI  = 4'b1100;
  localparam logic [3:0] MTLO  = 4'b1101;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op      = 4'b0000;
  logic [31:0] rs      = '0;
  logic [31:0] rt      = '0;
  logic        busy_o, done_o, dbz_o;
  logic [31:0] hi_o, lo_o;

  int checks    = 0;
  int failures  = 0;
  int busy_cnt  = 0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .alu_operation_i(op), .start_i(start_i),
    .rs_data_i(rs), .rt_data_i(rt), .busy_o(busy_o), .done_o(done_o),
    .div_by_zero_o(dbz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: an accepted MULTU/DIVU computes its answer at once and releases it 32 edges later.
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic        m_dbz = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] prod;

  always @(posedge clk) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
      end
    end else if (start_i) begin
      case (op)
        MULTU: begin
          prod = {32'b0, rs} * {32'b0, rt};
          r_hi = prod[63:32]; r_lo = prod[31:0];
          m_left = 32; m_dbz = 1'b0;
        end
        DIVU: begin
          if (rt == 0) begin
            m_hi = rs; m_lo = 32'hFFFF_FFFF; m_dbz = 1'b1; m_done = 1'b1;
          end else begin
            r_lo = rs / rt; r_hi = rs % rt;
            m_left = 32; m_dbz = 1'b0;
          end
        end
        MTHI: m_hi = rs;
        MTLO: m_lo = rs;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    chk("model_busy", {63'b0, busy_o}, {63'b0, (m_left > 0)});
    chk("model_done", {63'b0, done_o}, {63'b0, m_done});
    chk("model_dbz",  {63'b0, dbz_o},  {63'b0, m_dbz});
    chk("model_hi",   {32'b0, hi_o},   {32'b0, m_hi});
    chk("model_lo",   {32'b0, lo_o},   {32'b0, m_lo});
    if (busy_o) busy_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start_i = 1'b0; rs = $urandom; rt = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || done_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_o || done_o) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy%0b_done%0b required=idle", busy_o, done_o);
    end
  endtask

  logic [31:0] a, b, save_hi, save_lo;
  logic [3:0]  rop;
  int          k;

  initial begin
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'b0, hi_o}, 64'h0);
    chk("rst_lo", {32'b0, lo_o}, 64'h0);
    chk("rst_busy", {63'b0, busy_o}, 64'h0);
    chk("rst_done", {63'b0, done_o}, 64'h0);
    chk("rst_dbz", {63'b0, dbz_o}, 64'h0);
    reset = 1'b1;

    busy_cnt = 0; done_cnt = 0;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("mul_max_hi", {32'b0, hi_o}, 64'hFFFF_FFFE);
    chk("mul_max_lo", {32'b0, lo_o}, 64'h0000_0001);
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_done_pulses", done_cnt, 1);

    issue(DIVU, 32'd100, 32'd7);
    wait_idle();
    chk("div100_7_lo", {32'b0, lo_o}, 64'd14);
    chk("div100_7_hi", {32'b0, hi_o}, 64'd2);
    chk("div100_7_dbz", {63'b0, dbz_o}, 64'd0);
    issue(DIVU, 32'd5, 32'd9);
    wait_idle();
    chk("div5_9_lo", {32'b0, lo_o}, 64'd0);
    chk("div5_9_hi", {32'b0, hi_o}, 64'd5);

    busy_cnt = 0; done_cnt = 0;
    issue(DIVU, 32'h1234_5678, 32'h0);
    chk("dbz_hi", {32'b0, hi_o}, 64'h1234_5678);
    chk("dbz_lo", {32'b0, lo_o}, 64'hFFFF_FFFF);
    chk("dbz_flag", {63'b0, dbz_o}, 64'd1);
    chk("dbz_done", {63'b0, done_o}, 64'd1);
    wait_idle();
    chk("dbz_never_busy", busy_cnt, 0);
    issue(MULTU, 32'd3, 32'd4);
    wait_idle();
    chk("mul3_4_hi", {32'b0, hi_o}, 64'd0);
    chk("mul3_4_lo", {32'b0, lo_o}, 64'd12);
    chk("mul3_4_dbz_clr", {63'b0, dbz_o}, 64'd0);

    @(negedge clk);
    start_i = 1'b1; op = MTHI; rs = 32'hDEAD_BEEF;
    @(negedge clk);
    op = MTLO; rs = 32'hCAFE_F00D;
    @(negedge clk);
    start_i = 1'b0;
    chk("mthi", {32'b0, hi_o}, 64'hDEAD_BEEF);
    chk("mtlo", {32'b0, lo_o}, 64'hCAFE_F00D);
    chk("mt_no_busy", {63'b0, busy_o}, 64'd0);

    issue(MULTU, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    start_i = 1'b1; op = MULTU; rs = 32'hFFFF; rt = 32'hFFFF;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    chk("restart_ign_hi", {32'b0, hi_o}, 64'h0);
    chk("restart_ign_lo", {32'b0, lo_o}, 64'h0626_0060);

    done_cnt = 0;
    issue(MULTU, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_hi", {32'b0, hi_o}, 64'h0);
    chk("midrst_lo", {32'b0, lo_o}, 64'h0);
    chk("midrst_busy", {63'b0, busy_o}, 64'h0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    reset = 1'b1;
    issue(MULTU, 32'd6, 32'd7);
    wait_idle();
    chk("mul6_7_lo", {32'b0, lo_o}, 64'd42);

    save_hi = hi_o; save_lo = lo_o;
    @(negedge clk);
    start_i = 1'b1; op = 4'b0011; rs = 32'h5555_AAAA; rt = 32'h1;
    @(negedge clk);
    start_i = 1'b0;
    chk("badop_busy", {63'b0, busy_o}, 64'd0);
    chk("badop_done", {63'b0, done_o}, 64'd0);
    chk("badop_hi", {32'b0, hi_o}, {32'b0, save_hi});
    chk("badop_lo", {32'b0, lo_o}, {32'b0, save_lo});

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 6);
      a = $urandom;
      b = $urandom;
      case (k)
        0, 1: rop = MULTU;
        2:    rop = DIVU;
        3:    begin rop = DIVU; b = $urandom_range(0, 15); end
        4:    rop = MTHI;
        5:    rop = MTLO;
        default: rop = 4'($urandom_range(0, 9));
      endcase
      if (k == 2 && (i % 4) == 0) a = a >> $urandom_range(8, 31);
      issue(rop, a, b);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative unsigned multiply/divide unit with HI/LO registers for the MIPS datapath. It sits directly downstream of the ALU control decoder and consumes its 4-bit operation code alongside the register-file operands. It executes the extended operations that the single-cycle ALU cannot complete in one cycle (MULTU, DIVU) and services MTHI/MTLO. MFHI/MFLO read `hi_o`/`lo_o` combinationally; the top level stalls the PC while `busy_o` is high.

## Interface
- `DATA_WIDTH`, 32, operand and HI/LO width; iteration count equals `DATA_WIDTH`.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_operation_i`  in  4  operation code from ALU control; sampled only when `start_i`=1 in IDLE.
- `start_i`  in  1  request strobe.
- `rs_data_i`  in  32  operand A (dividend / multiplicand / MTHI/MTLO source).
- `rt_data_i`  in  32  operand B (divisor / multiplier).
- `busy_o`  out  1  high while in RUN.
- `done_o`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_by_zero_o`  out  1  registered; set on DIVU with B=0, cleared on the next accepted MULTU or DIVU.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.

## Operation
- Op codes: 4'b1010 MULTU, 4'b1011 DIVU, 4'b1100 MTHI, 4'b1101 MTLO. Any other code with `start_i`=1 is ignored, and no state changes.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start_i`=1 with MULTU or DIVU → RUN. Load the operands and clear the 6-bit iteration counter.
  - IDLE: DIVU with B=0 → DONE directly. HI←A, LO←32'hFFFF_FFFF, `div_by_zero_o`←1.
  - IDLE: MTHI → HI←A, or MTLO → LO←A, on the same edge. Stay in IDLE; no `busy_o`, no `done_o`.
  - RUN: one iteration per clock; counter increments. The edge that performs iteration `DATA_WIDTH`-1 writes HI/LO and moves to DONE.
  - DONE: `done_o`=1 for exactly one cycle, then → IDLE unconditionally.
- `start_i` in RUN or DONE is ignored and not queued. The requester must re-assert it in IDLE.
- MULTU: shift-add over a 64-bit accumulator. Result {HI,LO} = A×B (full 64-bit unsigned).
- DIVU: restoring division with a 33-bit partial remainder. LO = A/B, HI = A mod B (unsigned).
- HI/LO change only on MTHI/MTLO, a completing MULTU/DIVU, or reset. Internal working registers must not be visible on `hi_o`/`lo_o` during RUN.
- `busy_o` = (state==RUN). `done_o` = (state==DONE). Both are decoded from registered state, so they are glitch-free.

## Timing
- Reset (asynchronous, any time, including mid-RUN): state←IDLE, counter←0, HI←0, LO←0, `busy_o`=0, `done_o`=0, `div_by_zero_o`=0. The in-flight operation is discarded.
- MULTU/DIVU accepted at edge E0: `busy_o` is high from E0 to E32. HI/LO are written at E32. `done_o` is high between E32 and E33. The unit is back in IDLE at E33, so the next `start_i` is accepted at E33 at the earliest.
- Latency from start edge to valid HI/LO is 32 clocks (`DATA_WIDTH`).
- DIVU with B=0 at E0: HI/LO are written at E0, `done_o` is high E0–E1, and `busy_o` never rises.
- MTHI/MTLO: the written value is visible on `hi_o`/`lo_o` one edge after acceptance.
- Operands are captured at E0. Changes on `rs_data_i`/`rt_data_i` after E0 have no effect.

## Test plan
- Reset, then MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF → at E32 HI=32'hFFFF_FFFE, LO=32'h0000_0001. `busy_o` is high for 32 cycles, and `done_o` is a single pulse.
- DIVU A=100, B=7 → LO=14, HI=2, `div_by_zero_o`=0. With A=5, B=9 → LO=0, HI=5.
- DIVU A=32'h1234_5678, B=0 → next cycle HI=32'h1234_5678, LO=32'hFFFF_FFFF, `div_by_zero_o`=1, `busy_o` stays 0. A following MULTU 3×4 clears the flag, giving HI=0, LO=12.
- MTHI 32'hDEAD_BEEF then MTLO 32'hCAFE_F00D on consecutive cycles → `hi_o`/`lo_o` show those values. Repeating `start_i` with MULTU during RUN is ignored; the result matches the first operands only.
- Assert reset at E10 of a MULTU 6×7 → HI=LO=0, `busy_o`=0, and `done_o` is never pulsed. After release, MULTU 6×7 → LO=42.
- Op code 4'b0011 with `start_i` → no state change, HI/LO unchanged, `busy_o`/`done_o` stay 0.
